// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's dcache_* request interface.
// Accepts one request at a time, performs a byte-enabled word write or a
// full-word read on an internal array, and answers with a one-cycle
// dcache_ready pulse LATENCY cycles after the request was accepted.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range detection on
// dcache_addr[31:2] with a dmem_err pulse; otherwise addresses wrap).
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dcache_valid,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    input  logic [3:0]  dcache_byte_enable,
    output logic        dcache_ready,
    output logic [31:0] dcache_rdata,
    output logic        dmem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               enter_resp;
    logic [3:0]         count;

    // Request fields frozen from accept until the end of RESP
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               oor_q;

    // Incoming and selected request fields
    logic [IDX_W-1:0]   in_idx;
    logic               in_oor;
    logic [IDX_W-1:0]   sel_idx;
    logic [3:0]         sel_be;
    logic               sel_oor;

    logic               ready_q;
    logic [31:0]        rdata_q;

    logic [31:0]        mem [DEPTH_WORDS];

    assign in_idx = dcache_addr[2 +: IDX_W];

`ifdef DMEM_RANGE_CHECK_EN
    logic addr_unused;
    assign in_oor      = |dcache_addr[31:2+IDX_W];
    assign addr_unused = ^dcache_addr[1:0];
`else
    logic addr_unused;
    assign in_oor      = 1'b0;
    assign addr_unused = ^{dcache_addr[31:2+IDX_W], dcache_addr[1:0]};
`endif

    // With LATENCY==1 RESP is entered straight from IDLE, before the
    // request has been latched, so the live inputs feed the array read.
    assign sel_idx = (state == IDLE) ? in_idx : idx_q;
    assign sel_be  = (state == IDLE) ? dcache_byte_enable : be_q;
    assign sel_oor = (state == IDLE) ? in_oor : oor_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; inputs only matter in IDLE
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (dcache_valid) begin
                    accept     = 1'b1;
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign enter_resp = (next_state == RESP);

    // Wait-state counter: loaded on accept, counts down while in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (accept) begin
            count <= 4'(LATENCY - 1);
        end else if (state == WAIT && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= in_idx;
            wdata_q <= dcache_wdata;
            be_q    <= dcache_byte_enable;
            oor_q   <= in_oor;
        end
    end

    // Registered response: ready pulse and read data for the RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= enter_resp;
            if (enter_resp && sel_be == 4'b0000 && !sel_oor) begin
                rdata_q <= mem[sel_idx];
            end else begin
                rdata_q <= 32'd0;
            end
        end
    end

    // Byte-lane write at the edge that ends RESP; reset drops it because
    // the state has already been forced back to IDLE
    always_ff @(posedge clk) begin
        if (state == RESP && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;

    // Out-of-range flag raised alongside the ready pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp && sel_oor;
        end
    end

    assign dmem_err = err_q;
`else
    assign dmem_err = 1'b0;
`endif

    assign dcache_ready = ready_q;
    assign dcache_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 7)
// sharing one clock and reset, driven and sampled on the falling edge.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  valid;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic [2:0]  ready;
    logic [31:0] rdata [3];
    logic [2:0]  err;

    int checks   = 0;
    int failures = 0;
    int lat_of [3] = '{2, 1, 7};

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .dcache_valid(valid[0]), .dcache_addr(addr[0]),
        .dcache_wdata(wdata[0]), .dcache_byte_enable(be[0]), .dcache_ready(ready[0]),
        .dcache_rdata(rdata[0]), .dmem_err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .dcache_valid(valid[1]), .dcache_addr(addr[1]),
        .dcache_wdata(wdata[1]), .dcache_byte_enable(be[1]), .dcache_ready(ready[1]),
        .dcache_rdata(rdata[1]), .dmem_err(err[1])
    );

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(7)) u_l7 (
        .clk(clk), .rst_n(rst_n), .dcache_valid(valid[2]), .dcache_addr(addr[2]),
        .dcache_wdata(wdata[2]), .dcache_byte_enable(be[2]), .dcache_ready(ready[2]),
        .dcache_rdata(rdata[2]), .dmem_err(err[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b);
        valid[k] = 1'b1;
        addr[k]  = a;
        wdata[k] = wd;
        be[k]    = b;
    endtask

    // Waits for the ready pulse (bounded), scrambling inputs after accept,
    // then checks latency, response data, error flag and pulse width.
    task automatic finish_txn(input int k, input logic [31:0] exp_rd, input logic exp_err,
                              input string tag);
        int          cyc;
        bit          seen;
        logic [31:0] a;
        a    = addr[k];
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            valid[k] = 1'b0;
            addr[k]  = a + 32'd4;
            wdata[k] = ~wdata[k];
            be[k]    = ~be[k];
            if (ready[k]) seen = 1'b1;
        end
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat_of[k]));
        chk({tag, "_rdata"}, rdata[k], exp_rd);
        chk({tag, "_err"}, 32'(err[k]), 32'(exp_err));
        @(negedge clk);
        be[k] = 4'b0000;
        chk({tag, "_pulse_end"}, 32'(ready[k]), 32'd0);
    endtask

    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        @(negedge clk);
        launch(k, a, wd, b);
        finish_txn(k, exp_rd, exp_err, tag);
    endtask

    initial begin
        bit          any_ready;
        logic [31:0] oor_exp_rd;
        logic        oor_exp_err;
        logic [31:0] word0_after;

        rst_n = 1'b0;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
            be[i]    = 4'd0;
        end

        // Reset state
        @(negedge clk);
        chk("reset_ready", 32'(ready[0]), 32'd0);
        chk("reset_rdata", rdata[0], 32'd0);
        chk("reset_err", 32'(err[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Prior contents of 0x10
        txn(0, 32'h10, 32'h12345678, 4'hF, 32'd0, 1'b0, "init_0x10");

        // Reset in the middle of WAIT on a write of DEADBEEF
        @(negedge clk);
        launch(0, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ready", 32'(ready[0]), 32'd0);
        chk("rst_wait_rdata", rdata[0], 32'd0);
        any_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready[0]) any_ready = 1'b1;
        end
        chk("rst_wait_no_pulse", 32'(any_ready), 32'd0);
        // Request in the first cycle after reset release
        rst_n = 1'b1;
        launch(0, 32'h10, 32'd0, 4'h0);
        finish_txn(0, 32'h12345678, 1'b0, "rd_after_rst_wait");

        // Reset asserted during RESP of a write
        @(negedge clk);
        launch(0, 32'h10, 32'hBADC0DE5, 4'hF);
        @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_resp_ready_before", 32'(ready[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_ready_after", 32'(ready[0]), 32'd0);
        chk("rst_resp_rdata_after", rdata[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 32'h10, 32'd0, 4'h0, 32'h12345678, 1'b0, "rd_after_rst_resp");

        // Full-word write/read
        txn(0, 32'h40, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, "wr_cafef00d");
        txn(0, 32'h40, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, "rd_cafef00d");

        // Byte lanes
        txn(0, 32'h80, 32'h11223344, 4'hF, 32'd0, 1'b0, "wr_11223344");
        txn(0, 32'h80, 32'h00AA0000, 4'b0100, 32'd0, 1'b0, "wr_lane2");
        txn(0, 32'h80, 32'd0, 4'h0, 32'h11AA3344, 1'b0, "rd_lane2");
        txn(0, 32'h80, 32'h55FFFF66, 4'b1001, 32'd0, 1'b0, "wr_lane30");
        txn(0, 32'h80, 32'd0, 4'h0, 32'h55AA3366, 1'b0, "rd_lane30");

        // Back-to-back with valid held through RESP, address changed in WAIT
        txn(0, 32'h44, 32'h77778888, 4'hF, 32'd0, 1'b0, "wr_0x44");
        @(negedge clk);
        launch(0, 32'h40, 32'd0, 4'h0);
        @(negedge clk);
        chk("b2b_wait1", 32'(ready[0]), 32'd0);
        @(negedge clk);
        chk("b2b_resp1_ready", 32'(ready[0]), 32'd1);
        chk("b2b_resp1_rdata", rdata[0], 32'hCAFEF00D);
        addr[0] = 32'h44;
        @(negedge clk);
        chk("b2b_idle", 32'(ready[0]), 32'd0);
        @(negedge clk);
        valid[0] = 1'b0;
        addr[0]  = 32'h80;
        chk("b2b_wait2", 32'(ready[0]), 32'd0);
        @(negedge clk);
        chk("b2b_resp2_ready", 32'(ready[0]), 32'd1);
        chk("b2b_resp2_rdata", rdata[0], 32'h77778888);
        @(negedge clk);
        chk("b2b_done", 32'(ready[0]), 32'd0);

        // Latency sweep
        txn(1, 32'h8, 32'hA5A50001, 4'hF, 32'd0, 1'b0, "l1_wr");
        txn(1, 32'h8, 32'd0, 4'h0, 32'hA5A50001, 1'b0, "l1_rd");
        txn(2, 32'hC, 32'h5A5A0007, 4'hF, 32'd0, 1'b0, "l7_wr");
        txn(2, 32'hC, 32'd0, 4'h0, 32'h5A5A0007, 1'b0, "l7_rd");

        // Range handling at DEPTH_WORDS=4096
        txn(0, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, "wr_word0");
`ifdef DMEM_RANGE_CHECK_EN
        oor_exp_rd  = 32'd0;
        oor_exp_err = 1'b1;
        word0_after = 32'h0BADF00D;
`else
        oor_exp_rd  = 32'h0BADF00D;
        oor_exp_err = 1'b0;
        word0_after = 32'hFFFFFFFF;
`endif
        txn(0, 32'h4000, 32'd0, 4'h0, oor_exp_rd, oor_exp_err, "rd_0x4000");
        txn(0, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'd0, oor_exp_err, "wr_0x4000");
        txn(0, 32'h0, 32'd0, 4'h0, word0_after, 1'b0, "rd_word0_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
